// File: rtl/lutram_mport_clr_pkg.sv
// Shared types and elaboration helpers for the multi-port distributed RAM.
package lutram_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic bit params_legal(input int unsigned num_rd,
                                      input int unsigned rd_reg,
                                      input int unsigned wr_mode);
    return (num_rd >= 1) && (num_rd <= 8) && (rd_reg <= 1) && (wr_mode <= 1);
  endfunction

endpackage

// File: rtl/lutram_mport_clr_if.sv
// Write/clear/read bus of the multi-port RAM; slave side is the RAM.
interface lutram_mport_clr_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned NUM_RD = 4
);
  logic                       clr;
  logic                       busy;
  logic                       we;
  logic [ADDR_W-1:0]          waddr;
  logic [DATA_W-1:0]          wdata;
  logic [NUM_RD*ADDR_W-1:0]   raddr;
  logic [NUM_RD*DATA_W-1:0]   rdata;

  modport slave (
    input  clr, we, waddr, wdata, raddr,
    output busy, rdata
  );

  modport master (
    output clr, we, waddr, wdata, raddr,
    input  busy, rdata
  );
endinterface

// File: rtl/lutram_mport_clr_rd_port.sv
// One read port: array mux, optional write-first bypass, clear masking, optional output register.
module lutram_rd_port
  import lutram_pkg::*;
#(
  parameter int unsigned      ADDR_W  = 6,
  parameter int unsigned      DATA_W  = 4,
  parameter int unsigned      RD_REG  = 0,
  parameter int unsigned      WR_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL = '0,
  parameter int unsigned      DEPTH   = depth_of(ADDR_W)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_mem [DEPTH],
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_busy,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] r_rdata;

  always_comb begin
    w_sel = i_mem[i_raddr];
    if ((WR_MODE != 0) && i_wr_en && (i_waddr == i_raddr)) begin
      w_sel = i_wdata;
    end
    if (i_busy) begin
      w_sel = CLR_VAL;
    end
  end

  // Register exists in both modes; async mode simply bypasses it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= CLR_VAL;
    end else begin
      r_rdata <= w_sel;
    end
  end

  assign o_rdata = (RD_REG != 0) ? r_rdata : w_sel;

endmodule

// File: rtl/lutram_mport_clr.sv
// Distributed RAM: one write port, NUM_RD read ports, clear sweep sequencer.
module lutram_mport_clr
  import lutram_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 6,
  parameter int unsigned       DATA_W     = 4,
  parameter int unsigned       NUM_RD     = 4,
  parameter int unsigned       RD_REG     = 0,
  parameter int unsigned       WR_MODE    = 0,
  parameter logic [DATA_W-1:0] CLR_VAL    = '0,
  parameter int unsigned       CLR_ON_RST = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  lutram_mport_clr_if.slave   bus
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  if (!params_legal(NUM_RD, RD_REG, WR_MODE)) begin : g_bad_params
    $error("lutram_mport_clr: illegal NUM_RD/RD_REG/WR_MODE");
  end

  logic [DATA_W-1:0]        r_mem [DEPTH] = '{default: CLR_VAL};
  state_t                   r_state;
  logic [ADDR_W-1:0]        r_cnt;
  logic                     r_busy;
  logic                     w_wr_en;
  logic                     w_mem_we;
  logic [ADDR_W-1:0]        w_mem_addr;
  logic [DATA_W-1:0]        w_mem_data;
  logic [NUM_RD*DATA_W-1:0] w_rdata;

  assign w_wr_en = bus.we & ~r_busy;

  // Reset never writes the array; the sweep owns the write port while clearing.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = bus.waddr;
    w_mem_data = bus.wdata;
    if (i_rst_n) begin
      if (r_state == ST_CLEAR) begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_cnt;
        w_mem_data = CLR_VAL;
      end else begin
        w_mem_we   = w_wr_en;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      if (CLR_ON_RST != 0) begin
        r_state <= ST_CLEAR;
        r_busy  <= 1'b1;
      end else begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.clr) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    lutram_rd_port #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .RD_REG  (RD_REG),
      .WR_MODE (WR_MODE),
      .CLR_VAL (CLR_VAL),
      .DEPTH   (DEPTH)
    ) u_rd (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_mem   (r_mem),
      .i_raddr (bus.raddr[k*ADDR_W +: ADDR_W]),
      .i_busy  (r_busy),
      .i_wr_en (w_wr_en),
      .i_waddr (bus.waddr),
      .i_wdata (bus.wdata),
      .o_rdata (w_rdata[k*DATA_W +: DATA_W])
    );
  end

  assign bus.rdata = w_rdata;

endmodule

// File: tb/tb_lutram_mport_clr.sv
// Directed bench: three 64x4 variants plus a 256x16 registered variant without reset sweep.
module tb_lutram_mport_clr;

  logic clk;
  logic rst_n;

  logic        clr, we;
  logic [5:0]  waddr;
  logic [3:0]  wdata;
  logic [23:0] raddr;

  logic        clr_b, we_b;
  logic [7:0]  waddr_b;
  logic [15:0] wdata_b;
  logic [15:0] raddr_b;

  int unsigned passed;
  int unsigned total;

  lutram_mport_clr_if #(.ADDR_W(6), .DATA_W(4), .NUM_RD(4)) bus0 ();
  lutram_mport_clr_if #(.ADDR_W(6), .DATA_W(4), .NUM_RD(4)) bus1 ();
  lutram_mport_clr_if #(.ADDR_W(6), .DATA_W(4), .NUM_RD(4)) bus2 ();
  lutram_mport_clr_if #(.ADDR_W(8), .DATA_W(16), .NUM_RD(2)) bus3 ();

  assign bus0.clr = clr;  assign bus0.we = we;  assign bus0.waddr = waddr;
  assign bus0.wdata = wdata;  assign bus0.raddr = raddr;
  assign bus1.clr = clr;  assign bus1.we = we;  assign bus1.waddr = waddr;
  assign bus1.wdata = wdata;  assign bus1.raddr = raddr;
  assign bus2.clr = clr;  assign bus2.we = we;  assign bus2.waddr = waddr;
  assign bus2.wdata = wdata;  assign bus2.raddr = raddr;
  assign bus3.clr = clr_b;  assign bus3.we = we_b;  assign bus3.waddr = waddr_b;
  assign bus3.wdata = wdata_b;  assign bus3.raddr = raddr_b;

  // d0: async read-first, d1: async write-first, d2: registered write-first
  lutram_mport_clr #(.RD_REG(0), .WR_MODE(0)) u_d0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
  lutram_mport_clr #(.RD_REG(0), .WR_MODE(1)) u_d1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
  lutram_mport_clr #(.RD_REG(1), .WR_MODE(1)) u_d2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));
  lutram_mport_clr #(
    .ADDR_W(8), .DATA_W(16), .NUM_RD(2), .RD_REG(1), .WR_MODE(0),
    .CLR_VAL(16'hDEAD), .CLR_ON_RST(0)
  ) u_d3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [5:0] a, input logic [3:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic test_reset;
    int unsigned n;
    repeat (2) @(negedge clk);
    total++; if (bus0.busy !== 1'b1) $display("FAIL rst_busy_d0: got %b expected 1", bus0.busy); else passed++;
    total++; if (bus3.busy !== 1'b0) $display("FAIL rst_busy_d3: got %b expected 0", bus3.busy); else passed++;
    total++; if (bus2.rdata !== 16'h0000) $display("FAIL rst_rdata_d2: got %h expected 0000", bus2.rdata); else passed++;
    total++; if (bus3.rdata !== 32'hDEADDEAD) $display("FAIL rst_rdata_d3: got %h expected deaddead", bus3.rdata); else passed++;
    rst_n = 1'b1;
    n = 0;
    while (bus0.busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    total++; if (n != 64) $display("FAIL rst_sweep_len: got %0d cycles expected 64", n); else passed++;
    total++; if (bus3.busy !== 1'b0) $display("FAIL rst_noclr_d3: got %b expected 0", bus3.busy); else passed++;
    raddr = {6'd63, 6'd31, 6'd0, 6'd0};
    #1;
    total++; if (bus0.rdata !== 16'h0000) $display("FAIL post_sweep_d0: got %h expected 0000", bus0.rdata); else passed++;
    @(posedge clk); #1;
    total++; if (bus2.rdata !== 16'h0000) $display("FAIL post_sweep_d2: got %h expected 0000", bus2.rdata); else passed++;
  endtask

  task automatic test_write_read;
    wr(6'd5, 4'hA);
    wr(6'd63, 4'h3);
    wr(6'd0, 4'hF);
    raddr = {6'd63, 6'd5, 6'd0, 6'd5};
    #1;
    total++; if (bus0.rdata !== 16'h3AFA) $display("FAIL wr_rd_d0: got %h expected 3afa", bus0.rdata); else passed++;
    total++; if (bus1.rdata !== 16'h3AFA) $display("FAIL wr_rd_d1: got %h expected 3afa", bus1.rdata); else passed++;
    total++; if (bus2.rdata !== 16'h30FF) $display("FAIL wr_rd_d2_lat: got %h expected 30ff", bus2.rdata); else passed++;
    @(posedge clk); #1;
    total++; if (bus2.rdata !== 16'h3AFA) $display("FAIL wr_rd_d2: got %h expected 3afa", bus2.rdata); else passed++;
  endtask

  task automatic test_collision;
    wr(6'd9, 4'h1);
    @(negedge clk);
    raddr = {4{6'd9}};
    we = 1'b1; waddr = 6'd9; wdata = 4'h7;
    #1;
    total++; if (bus0.rdata !== 16'h1111) $display("FAIL coll_rf_d0: got %h expected 1111", bus0.rdata); else passed++;
    total++; if (bus1.rdata !== 16'h7777) $display("FAIL coll_wf_d1: got %h expected 7777", bus1.rdata); else passed++;
    @(posedge clk); #1;
    we = 1'b0;
    total++; if (bus0.rdata !== 16'h7777) $display("FAIL coll_after_d0: got %h expected 7777", bus0.rdata); else passed++;
    total++; if (bus2.rdata !== 16'h7777) $display("FAIL coll_wf_d2: got %h expected 7777", bus2.rdata); else passed++;
  endtask

  task automatic test_clear;
    int unsigned n;
    wr(6'd12, 4'hC);
    raddr = {4{6'd12}};
    #1;
    total++; if (bus0.rdata !== 16'hCCCC) $display("FAIL clr_pre_d0: got %h expected cccc", bus0.rdata); else passed++;
    @(negedge clk);
    clr = 1'b1;
    #1;
    total++; if (bus0.busy !== 1'b0) $display("FAIL clr_busy_early: got %b expected 0", bus0.busy); else passed++;
    @(posedge clk); #1;
    clr = 1'b0;
    n = 0;
    while (bus0.busy === 1'b1 && n < 300) begin
      n++;
      if (n == 1) begin
        total++; if (bus2.rdata !== 16'hCCCC) $display("FAIL clr_mask_lag_d2: got %h expected cccc", bus2.rdata); else passed++;
      end
      if (n == 2) begin
        total++; if (bus0.rdata !== 16'h0000) $display("FAIL clr_mask_d0: got %h expected 0000", bus0.rdata); else passed++;
        total++; if (bus2.rdata !== 16'h0000) $display("FAIL clr_mask_d2: got %h expected 0000", bus2.rdata); else passed++;
      end
      clr = (n == 20);
      if (n == 30) begin
        we = 1'b1; waddr = 6'd12; wdata = 4'h5;
      end else begin
        we = 1'b0;
      end
      @(posedge clk); #1;
    end
    clr = 1'b0; we = 1'b0;
    total++; if (n != 64) $display("FAIL clr_sweep_len: got %0d cycles expected 64", n); else passed++;
    #1;
    total++; if (bus0.rdata !== 16'h0000) $display("FAIL clr_after_d0: got %h expected 0000", bus0.rdata); else passed++;
    total++; if (bus1.rdata !== 16'h0000) $display("FAIL clr_after_d1: got %h expected 0000", bus1.rdata); else passed++;
  endtask

  task automatic test_reset_mid_sweep;
    int unsigned n;
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    while (bus0.busy === 1'b1 && n < 300) begin
      n++;
      @(posedge clk); #1;
    end
    total++; if (n != 64) $display("FAIL mid_rst_sweep_len: got %0d cycles expected 64", n); else passed++;
  endtask

  task automatic test_big_config;
    int unsigned n;
    raddr_b = {8'd201, 8'd200};
    @(negedge clk);
    we_b = 1'b1; waddr_b = 8'd200; wdata_b = 16'h1234;
    @(posedge clk); #1;
    we_b = 1'b0;
    total++; if (bus3.rdata !== 32'hDEADDEAD) $display("FAIL big_coll_rf: got %h expected deaddead", bus3.rdata); else passed++;
    @(posedge clk); #1;
    total++; if (bus3.rdata !== 32'hDEAD1234) $display("FAIL big_rd: got %h expected dead1234", bus3.rdata); else passed++;
    @(negedge clk);
    clr_b = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0;
    n = 0;
    while (bus3.busy === 1'b1 && n < 600) begin
      n++;
      if (n == 250) begin
        we_b = 1'b1; waddr_b = 8'd200; wdata_b = 16'h5555;
      end else begin
        we_b = 1'b0;
      end
      @(posedge clk); #1;
    end
    we_b = 1'b0;
    total++; if (n != 256) $display("FAIL big_sweep_len: got %0d cycles expected 256", n); else passed++;
    @(posedge clk); #1;
    total++; if (bus3.rdata !== 32'hDEADDEAD) $display("FAIL big_after_clr: got %h expected deaddead", bus3.rdata); else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b0;
    clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    clr_b = 1'b0; we_b = 1'b0; waddr_b = '0; wdata_b = '0; raddr_b = '0;
    test_reset();
    test_write_read();
    test_collision();
    test_clear();
    test_reset_mid_sweep();
    test_big_config();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lutram_mport_clr.md
Name: lutram_mport_clr

Overview:
- Parametrised distributed-RAM block: one synchronous write port, NUM_RD independent read ports.
- Read ports are asynchronous or registered, selected by parameter.
- Selectable write-collision mode.
- Built-in clear sequencer sweeps the whole array to CLR_VAL after reset or on request.
- Used as register files, small lookup tables and descriptor stores wherever a fixed 64x4 primitive is too narrow or too shallow.

Parameters:
- ADDR_W, 6: address width; DEPTH = 2**ADDR_W words.
- DATA_W, 4: word width in bits.
- NUM_RD, 4: number of read ports, 1..8.
- RD_REG, 0: 0 = asynchronous read; 1 = read data registered, 1-cycle latency.
- WR_MODE, 0: 0 = read-first (old data on collision); 1 = write-first (WDATA bypassed on collision).
- CLR_VAL, {DATA_W{1'b0}}: value written by the clear sweep; also the power-up content.
- CLR_ON_RST, 1: 1 = start a clear sweep when reset is released; 0 = no sweep on reset.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  synchronous active-low reset.
- CLR  in  1  clear request; single-cycle pulse or level.
- BUSY  out  1  clear sweep in progress.
- WE  in  1  write enable.
- WADDR  in  ADDR_W  write address.
- WDATA  in  DATA_W  write data.
- RADDR  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- RDATA  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].

Behaviour:
- Storage: DEPTH x DATA_W array, initialised to CLR_VAL at power-up. The array is not touched by reset except through the sweep.
- FSM states: IDLE, CLEAR. Sweep counter cnt is ADDR_W bits wide.
- Reset (RST_N=0 at an edge):
  - CLR_ON_RST=1: state goes to CLEAR, cnt=0, BUSY=1.
  - CLR_ON_RST=0: state goes to IDLE, BUSY=0.
  - RDATA registers (RD_REG=1) reset to CLR_VAL.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- IDLE:
  - WE=1 writes WDATA to mem[WADDR] at the edge.
  - CLR=1 moves to CLEAR, cnt=0, BUSY=1 from the next cycle.
  - If WE and CLR are high in the same cycle, the write is performed, then the sweep starts.
- CLEAR:
  - Each cycle, mem[cnt] <= CLR_VAL and cnt increments.
  - When cnt==DEPTH-1, the last word is written and the state returns to IDLE; BUSY deasserts the following cycle.
  - A sweep occupies exactly DEPTH cycles with BUSY=1.
  - WE is ignored while BUSY=1; writes are dropped, not queued.
  - CLR is ignored while BUSY=1; the sweep does not restart.
- Read with RD_REG=0:
  - RDATA[k] = mem[RADDR[k]] combinationally.
  - WR_MODE=1 and WE & !BUSY & WADDR==RADDR[k]: RDATA[k] = WDATA combinationally.
- Read with RD_REG=1:
  - RDATA[k] is registered: it updates at the edge with the value selected by the RD_REG=0 rule above. Latency is 1 cycle.
  - Collision: WR_MODE=0 returns old data; WR_MODE=1 returns the new data.
- While BUSY=1, every RDATA port reads CLR_VAL, so stale data is never exposed. With RD_REG=1 this masking is registered and lags BUSY by 1 cycle.
- Port independence: all read ports may address the same word; no arbitration.
- Addresses wrap naturally at ADDR_W bits; there is no out-of-range condition.

Decomposition:
- Package lutram_pkg:
  - FSM state enum (ST_IDLE, ST_CLEAR).
  - Function depth_of(ADDR_W).
  - Parameter legality check: NUM_RD between 1 and 8, RD_REG and WR_MODE each 0 or 1.
- One sub-module, lutram_rd_port: one read port (mux, collision bypass, BUSY masking, optional output register), instantiated NUM_RD times in a generate loop.
- The write path and clear FSM stay in the top module.

Test Plan:
- Defaults, release reset -> BUSY=1 for exactly 64 cycles, then 0; all 4 ports read 4'h0 at addresses 0, 31 and 63.
- After the sweep: write 4'hA@5, 4'h3@63, 4'hF@0; set RADDR={63,5,0,5} -> RDATA={3,A,F,A}. With RD_REG=1 the same values appear 1 cycle after RADDR is applied.
- Collision: mem[9]=4'h1, then WE with WADDR=9, WDATA=4'h7, all RADDR=9.
  - WR_MODE=0 -> RDATA=4'h1 in that cycle; 4'h7 the next cycle.
  - WR_MODE=1 -> RDATA=4'h7 in that cycle.
- CLR pulse in IDLE with mem[12]=4'hC:
  - BUSY rises the next cycle.
  - WE (WADDR=12, WDATA=4'h5) issued during the sweep is dropped.
  - A second CLR at cycle 20 does not extend the sweep; BUSY lasts 64 cycles.
  - Afterwards mem[12] reads 4'h0.
- Reset mid-sweep at cnt=40 -> cnt restarts at 0; BUSY stays high for a further full 64 cycles.
- Config ADDR_W=8, DATA_W=16, NUM_RD=2, RD_REG=1, CLR_VAL=16'hDEAD, CLR_ON_RST=0:
  - After reset BUSY=0 immediately.
  - Write 16'h1234@200 -> read 16'h1234; address 201 reads 16'hDEAD.
  - CLR -> 256-cycle sweep; afterwards address 200 reads 16'hDEAD.
